// File: rtl/irda_mir_pkg.sv
// IrDA MIR deframer shared definitions:
// flag, CRC-16 constants and receive state encoding.
package irda_mir_pkg;

   localparam logic [7:0]  FLAG     = 8'h7E;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h8408;
   localparam logic [15:0] CRC_GOOD = 16'hF0B8;

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2
   } state_t;

endpackage

// File: rtl/irda_mir_crc16.sv
// Byte-wide reflected CRC-16 update, purely combinational.
// Data enters LSB first, matching the line bit order.
module irda_mir_crc16
   import irda_mir_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  byte_in,
   output logic [15:0] crc_out
);

   logic [15:0] w_c;

   always_comb begin
      w_c = crc_in ^ {8'h00, byte_in};
      for (int i = 0; i < 8; i++) begin
         if (w_c[0]) w_c = (w_c >> 1) ^ CRC_POLY;
         else        w_c = w_c >> 1;
      end
   end

   assign crc_out = w_c;

endmodule

// File: rtl/irda_mir_deframer.sv
// IrDA MIR receive deframer: flag hunt, zero destuffing,
// byte assembly, FCS check and abort detection.
module irda_mir_deframer
   import irda_mir_pkg::*;
(
   input  logic       clk,
   input  logic       wb_rst_i,
   input  logic       mir_mode,
   input  logic       tx_select,
   input  logic       bit_en,
   input  logic       rx_bit,
   output logic [7:0] data_o,
   output logic       data_valid_o,
   output logic       sof_o,
   output logic       eof_o,
   output logic       crc_ok_o,
   output logic       abort_o
);

   state_t      r_state, w_state_nx;
   logic [7:0]  r_shift, w_shift_nx;
   logic [7:0]  r_asm, w_asm_nx;
   logic [2:0]  r_bit_cnt, w_cnt_nx;
   logic [2:0]  r_ones, w_ones_nx;
   logic [15:0] r_crc, w_crc_nx;
   logic [1:0]  r_len, w_len_nx;
   logic [7:0]  w_data_nx;
   logic        w_dv_nx, w_sof_nx, w_eof_nx;
   logic        w_ok_nx, w_abort_nx;

   logic        w_active;
   logic [7:0]  w_byte;
   logic [7:0]  w_hunt;
   logic [15:0] w_crc_seed, w_crc_upd;
   logic [2:0]  w_ones_inc;

   assign w_active   = mir_mode & ~tx_select;
   assign w_byte     = {rx_bit, r_asm[7:1]};
   assign w_hunt     = {rx_bit, r_shift[7:1]};
   assign w_crc_seed = (r_state == ST_SYNC) ? CRC_INIT : r_crc;
   assign w_ones_inc = !rx_bit ? 3'd0 :
                       (r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1;

   irda_mir_crc16 u_crc (
      .crc_in  (w_crc_seed),
      .byte_in (w_byte),
      .crc_out (w_crc_upd)
   );

   always_comb begin
      w_state_nx = r_state;
      w_shift_nx = r_shift;
      w_asm_nx   = r_asm;
      w_cnt_nx   = r_bit_cnt;
      w_ones_nx  = r_ones;
      w_crc_nx   = r_crc;
      w_len_nx   = r_len;
      w_data_nx  = data_o;
      w_dv_nx    = 1'b0;
      w_sof_nx   = 1'b0;
      w_eof_nx   = 1'b0;
      w_ok_nx    = 1'b0;
      w_abort_nx = 1'b0;
      if (!w_active) begin
         w_state_nx = ST_HUNT;
         w_shift_nx = 8'h00;
         w_asm_nx   = 8'h00;
         w_cnt_nx   = 3'd0;
         w_ones_nx  = 3'd0;
         w_len_nx   = 2'd0;
      end else if (bit_en) begin
         w_ones_nx = w_ones_inc;
         unique case (r_state)
            ST_HUNT: begin
               w_shift_nx = w_hunt;
               if (w_hunt == FLAG) begin
                  w_state_nx = ST_SYNC;
                  w_cnt_nx   = 3'd0;
                  w_ones_nx  = 3'd0;
               end
            end
            ST_SYNC, ST_DATA: begin
               if (!rx_bit && r_ones == 3'd5) begin
                  // stuffed zero: dropped, only the run count resets
                  w_ones_nx = 3'd0;
               end else if (r_ones == 3'd6) begin
                  w_cnt_nx  = 3'd0;
                  w_ones_nx = 3'd0;
                  w_len_nx  = 2'd0;
                  if (rx_bit) begin
                     w_state_nx = ST_HUNT;
                     w_shift_nx = 8'h00;
                     w_abort_nx = (r_state == ST_DATA);
                  end else begin
                     w_state_nx = ST_SYNC;
                     if (r_state == ST_DATA) begin
                        w_eof_nx = 1'b1;
                        w_ok_nx  = (r_bit_cnt == 3'd7) &&
                                   (r_crc == CRC_GOOD) &&
                                   (r_len == 2'd3);
                     end
                  end
               end else begin
                  w_asm_nx = w_byte;
                  w_cnt_nx = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     w_dv_nx    = 1'b1;
                     w_data_nx  = w_byte;
                     w_crc_nx   = w_crc_upd;
                     w_state_nx = ST_DATA;
                     w_sof_nx   = (r_state == ST_SYNC);
                     if (r_state == ST_SYNC) w_len_nx = 2'd1;
                     else if (r_len != 2'd3) w_len_nx = r_len + 2'd1;
                  end
               end
            end
            default: w_state_nx = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wb_rst_i) begin
         r_state      <= ST_HUNT;
         r_shift      <= 8'h00;
         r_asm        <= 8'h00;
         r_bit_cnt    <= 3'd0;
         r_ones       <= 3'd0;
         r_crc        <= 16'h0000;
         r_len        <= 2'd0;
         data_o       <= 8'h00;
         data_valid_o <= 1'b0;
         sof_o        <= 1'b0;
         eof_o        <= 1'b0;
         crc_ok_o     <= 1'b0;
         abort_o      <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_shift      <= w_shift_nx;
         r_asm        <= w_asm_nx;
         r_bit_cnt    <= w_cnt_nx;
         r_ones       <= w_ones_nx;
         r_crc        <= w_crc_nx;
         r_len        <= w_len_nx;
         data_o       <= w_data_nx;
         data_valid_o <= w_dv_nx;
         sof_o        <= w_sof_nx;
         eof_o        <= w_eof_nx;
         crc_ok_o     <= w_ok_nx;
         abort_o      <= w_abort_nx;
      end
   end

endmodule

// File: tb/tb_irda_mir_deframer.sv
// Scoreboard bench for irda_mir_deframer: directed frames,
// expected events queued at stimulus, checked by a monitor.
module tb_irda_mir_deframer;

   logic       clk = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic       mir_mode = 1'b1;
   logic       tx_select = 1'b0;
   logic       bit_en = 1'b0;
   logic       rx_bit = 1'b0;
   logic [7:0] data_o;
   logic       data_valid_o, sof_o, eof_o, crc_ok_o, abort_o;

   irda_mir_deframer dut (
      .clk          (clk),
      .wb_rst_i     (wb_rst_i),
      .mir_mode     (mir_mode),
      .tx_select    (tx_select),
      .bit_en       (bit_en),
      .rx_bit       (rx_bit),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .sof_o        (sof_o),
      .eof_o        (eof_o),
      .crc_ok_o     (crc_ok_o),
      .abort_o      (abort_o)
   );

   always #5 clk = ~clk;

   // kind is {data_valid, eof, abort}
   typedef struct {
      logic [2:0] kind;
      logic [7:0] data;
      logic       sof;
      logic       ok;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] fr[$];
   int         n_pass = 0;
   int         n_total = 0;
   int         n_events = 0;
   int         tb_ones = 0;

   task automatic chk(input string nm, input logic [15:0] got,
                      input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", nm, got, exp);
   endtask

   task automatic push_data(input logic [7:0] d, input logic s);
      exp_t e;
      e.kind = 3'b100; e.data = d; e.sof = s; e.ok = 1'b0;
      sb.push_back(e);
   endtask

   task automatic push_eof(input logic ok);
      exp_t e;
      e.kind = 3'b010; e.data = 8'h00; e.sof = 1'b0; e.ok = ok;
      sb.push_back(e);
   endtask

   task automatic push_abort();
      exp_t e;
      e.kind = 3'b001; e.data = 8'h00; e.sof = 1'b0; e.ok = 1'b0;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (data_valid_o | eof_o | abort_o | sof_o) begin
         exp_t e;
         n_events++;
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_pulse dv=%b sof=%b eof=%b abort=%b",
                     data_valid_o, sof_o, eof_o, abort_o);
         end else begin
            e = sb.pop_front();
            chk("kind", {13'd0, data_valid_o, eof_o, abort_o},
                {13'd0, e.kind});
            chk("sof", {15'd0, sof_o}, {15'd0, e.sof});
            if (e.kind == 3'b100) chk("data", {8'd0, data_o}, {8'd0, e.data});
            if (e.kind == 3'b010) chk("crc_ok", {15'd0, crc_ok_o}, {15'd0, e.ok});
         end
      end
   end

   task automatic send_bit(input logic b);
      rx_bit = b;
      bit_en = 1'b1;
      @(posedge clk); #1;
      bit_en = 1'b0;
      @(posedge clk); #1;
      tb_ones = b ? tb_ones + 1 : 0;
   endtask

   task automatic send_flag();
      logic [7:0] f;
      f = 8'h7E;
      for (int i = 0; i < 8; i++) send_bit(f[i]);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         send_bit(v[i]);
         if (tb_ones == 5) send_bit(1'b0);
      end
   endtask

   task automatic send_frame(input logic ok);
      foreach (fr[i]) begin
         push_data(fr[i], i == 0);
         send_byte(fr[i]);
      end
      push_eof(ok);
      send_flag();
   endtask

   task automatic load_check_frame(input logic [7:0] fifth);
      fr = {8'h31, 8'h32, 8'h33, 8'h34, fifth, 8'h36,
            8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
   endtask

   task automatic chk_quiet(input string nm);
      chk(nm, {11'd0, data_valid_o, sof_o, eof_o, crc_ok_o, abort_o}, 16'd0);
   endtask

   initial begin
      int ev;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", {8'd0, data_o}, 16'h0000);
      chk_quiet("rst_outs");
      wb_rst_i = 1'b0;
      @(posedge clk); #1;

      // good check frame, opened from HUNT
      send_flag();
      load_check_frame(8'h35);
      send_frame(1'b1);

      // corrupted byte, opening flag shared with previous close
      load_check_frame(8'h34);
      send_frame(1'b0);

      // stuffed 0xFF payload with its FCS 0x00,0xFF
      fr = {8'hFF, 8'h00, 8'hFF};
      send_frame(1'b1);

      // misaligned closing flag releases 0xE0 then short eof
      push_data(8'h31, 1'b1);
      send_byte(8'h31);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      push_data(8'hE0, 1'b0);
      push_eof(1'b0);
      send_flag();

      // abort after one byte, then resync on a fresh flag
      push_data(8'h12, 1'b1);
      send_byte(8'h12);
      push_abort();
      for (int i = 0; i < 7; i++) send_bit(1'b1);
      send_flag();
      fr = {8'hA5};
      send_frame(1'b0);

      // idle flags produce nothing
      wb_rst_i = 1'b1;
      @(posedge clk); #1;
      wb_rst_i = 1'b0;
      ev = n_events;
      repeat (3) send_flag();
      repeat (4) @(posedge clk);
      #1;
      chk("idle_flags_events", ev[15:0], n_events[15:0]);

      // transmit direction mid-frame
      push_data(8'h31, 1'b1);
      send_byte(8'h31);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      tx_select = 1'b1;
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      chk_quiet("txsel_outs");
      tx_select = 1'b0;
      send_flag();
      load_check_frame(8'h35);
      send_frame(1'b1);

      // reset mid-frame
      push_data(8'h22, 1'b1);
      send_byte(8'h22);
      send_bit(1'b1);
      wb_rst_i = 1'b1;
      bit_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bit_en = 1'b0;
      chk("rstmid_data", {8'd0, data_o}, 16'h0000);
      chk_quiet("rstmid_outs");
      wb_rst_i = 1'b0;
      @(posedge clk); #1;
      send_flag();
      load_check_frame(8'h35);
      send_frame(1'b1);

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/irda_mir_deframer.md
IRDA_MIR_DEFRAMER -- requirements
Module: irda_mir_deframer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port mir_mode  input  1  MIR mode select; block active only when 1.
REQ-004 SHALL have port tx_select  input  1  transmit direction; block active only when 0.
REQ-005 SHALL have port bit_en  input  1  one-cycle strobe, one per decoded MIR bit.
REQ-006 SHALL have port rx_bit  input  1  decoded MIR bit, sampled when bit_en=1.
REQ-007 SHALL have port data_o  output  8  received payload byte, LSB first on line.
REQ-008 SHALL have port data_valid_o  output  1  one-cycle pulse; data_o valid.
REQ-009 SHALL have port sof_o  output  1  pulse coincident with first data_valid_o of a frame.
REQ-010 SHALL have port eof_o  output  1  one-cycle pulse at closing flag.
REQ-011 SHALL have port crc_ok_o  output  1  FCS check result; valid while eof_o=1.
REQ-012 SHALL have port abort_o  output  1  one-cycle pulse on abort sequence inside a frame.

Function
REQ-013 Active = mir_mode & ~tx_select; when inactive, SHALL return to HUNT, clear all counters, and drive all pulse outputs 0 (mid-frame: no eof_o).
REQ-014 Input processed only on cycles with active & bit_en; other cycles hold state.
REQ-015 States HUNT, SYNC, DATA; reset and inactive state is HUNT.
REQ-016 HUNT: 8-bit raw shift register of last rx_bits; match 8'h7E -> SYNC, bit_cnt=0, ones_cnt=0.
REQ-017 ones_cnt counts consecutive 1 bits, saturates at 7, clears on a 0 bit.
REQ-018 SYNC/DATA: a 0 bit arriving with ones_cnt=5 SHALL be discarded (stuffed zero); not shifted, not counted.
REQ-019 SYNC/DATA: other bits shifted into 8-bit assembler LSB first; bit_cnt 0..7, wraps at 8.
REQ-020 Flag = 0 bit arriving with ones_cnt=6.
REQ-021 Abort = 1 bit arriving with ones_cnt=6 (seventh 1): in DATA pulse abort_o, no eof_o; in SYNC no pulse; both -> HUNT.
REQ-022 Flag on the 8th assembler bit (aligned) SHALL discard the assembled byte; SYNC stays SYNC; DATA -> eof_o, crc_ok_o, then SYNC with counters cleared.
REQ-023 Flag not on the 8th bit in DATA SHALL give eof_o with crc_ok_o=0 -> SYNC; in SYNC -> SYNC, no output.
REQ-024 Completed non-flag byte SHALL pulse data_valid_o the cycle after the bit_en of its 8th bit; in SYNC also pulse sof_o, init CRC, -> DATA.
REQ-025 Each released byte, FCS bytes included, SHALL update CRC-16 (reflected poly 16'h8408, init 16'hFFFF).
REQ-026 crc_ok_o = 1 iff residue == 16'hF0B8 and frame length >= 3 bytes; otherwise 0.
REQ-027 eof_o/abort_o SHALL appear one cycle after the bit_en of the terminating bit; never together with data_valid_o.
REQ-028 Back-to-back flags, and a closing flag shared as the next opening flag, SHALL be accepted.

Reset
REQ-029 wb_rst_i=1 SHALL force HUNT, clear shift register, assembler, counters and CRC, set data_o=8'h00 and all 1-bit outputs 0 on the next edge, overriding active and bit_en.
REQ-030 Reset mid-frame SHALL emit no eof_o or abort_o.

Structure
REQ-031 Shared package irda_mir_pkg SHALL hold FLAG=8'h7E, CRC_INIT=16'hFFFF, CRC_POLY=16'h8408, CRC_GOOD=16'hF0B8 and the state encoding.
REQ-032 Byte-wise CRC update SHALL be a combinational sub-module irda_mir_crc16 (crc_in[15:0], byte[7:0] -> crc_out[15:0]).

Verification
REQ-033 Flag, ASCII "123456789" (0x31..0x39), FCS 0x6E,0x90, flag -> 11 data_valid_o, sof_o on 0x31, eof_o with crc_ok_o=1.
REQ-034 Same frame with byte 0x35 changed to 0x34 -> 11 bytes, eof_o with crc_ok_o=0.
REQ-035 Flag, byte 0xFF sent stuffed (1,1,1,1,1,0,1,1,1), FCS, flag -> data_o=0xFF, stuffed 0 dropped.
REQ-036 Flag, 0x12, then seven 1s -> one data_valid_o (0x12), abort_o pulse, no eof_o; next flag resyncs.
REQ-037 Three consecutive flags, no data -> no data_valid_o, sof_o or eof_o.
REQ-038 tx_select=1 or wb_rst_i=1 asserted mid-frame -> outputs 0, no eof_o; a new frame after release decodes correctly.
